// File: rtl/floating_point_rounder.sv
// floating_point_rounder: two-stage float32 rounding stage behind the multiplier.
// Applies the RISC-V rounding mode and tracks per-operation and sticky fflags.
module floating_point_rounder #(
   parameter logic [31:0] CANONICAL_NAN = 32'h7FC00000,
   parameter int unsigned ROUND_MODE_W  = 3
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic [31:0]             result_i,
   input  logic [2:0]              round_bits_i,
   input  logic                    invalid_operation_i,
   input  logic                    overflow_i,
   input  logic                    underflow_i,
   input  logic [ROUND_MODE_W-1:0] round_mode_i,
   input  logic                    data_valid_i,
   output logic                    ready_o,
   output logic                    data_valid_o,
   input  logic                    ready_i,
   output logic [31:0]             result_o,
   output logic [4:0]              flags_o,
   input  logic                    clear_flags_i,
   output logic [4:0]              acc_flags_o
);
   localparam logic [2:0] RNE = 3'd0;
   localparam logic [2:0] RTZ = 3'd1;
   localparam logic [2:0] RDN = 3'd2;
   localparam logic [2:0] RUP = 3'd3;
   localparam logic [2:0] RMM = 3'd4;

   function automatic logic round_up(input logic [2:0] mode, input logic sign,
                                     input logic [2:0] grs, input logic lsb);
      logic up;
      case (mode)
         RTZ:     up = 1'b0;
         RDN:     up = sign & (|grs);
         RUP:     up = ~sign & (|grs);
         RMM:     up = grs[2];
         default: up = grs[2] & (grs[1] | grs[0] | lsb);
      endcase
      return up;
   endfunction

   // Directed roundings saturate to max finite instead of infinity
   function automatic logic [31:0] overflow_value(input logic [2:0] mode, input logic sign);
      logic [31:0] v;
      case (mode)
         RTZ:     v = {sign, 31'h7F7FFFFF};
         RDN:     v = sign ? 32'hFF800000 : 32'h7F7FFFFF;
         RUP:     v = sign ? 32'hFF7FFFFF : 32'h7F800000;
         default: v = {sign, 31'h7F800000};
      endcase
      return v;
   endfunction

   logic        valid_a_q, valid_a_d;
   logic        sign_a_q, sign_a_d;
   logic [30:0] mag_a_q, mag_a_d;
   logic        inc_a_q, inc_a_d;
   logic        nx_a_q, nx_a_d;
   logic [2:0]  mode_a_q, mode_a_d;
   logic        nv_a_q, nv_a_d;
   logic        of_a_q, of_a_d;
   logic        uf_a_q, uf_a_d;
   logic        valid_b_q, valid_b_d;
   logic [31:0] result_q, result_d;
   logic [4:0]  flags_q, flags_d;
   logic [4:0]  acc_q, acc_d;

   logic        stall_s, in_xfer_s, out_xfer_s;
   logic [2:0]  mode_in_s;
   logic [30:0] sum_s;
   logic [31:0] res_s;
   logic [4:0]  flg_s;

   assign stall_s      = valid_b_q & ~ready_i;
   assign ready_o      = ~stall_s;
   assign in_xfer_s    = data_valid_i & ~stall_s;
   assign out_xfer_s   = valid_b_q & ready_i;
   assign mode_in_s    = (round_mode_i <= ROUND_MODE_W'(4)) ? round_mode_i[2:0] : RNE;
   assign data_valid_o = valid_b_q;
   assign result_o     = result_q;
   assign flags_o      = flags_q;
   assign acc_flags_o  = acc_q;

   // Stage A: capture the operand and decide the rounding increment
   always_comb begin
      valid_a_d = valid_a_q;
      sign_a_d  = sign_a_q;
      mag_a_d   = mag_a_q;
      inc_a_d   = inc_a_q;
      nx_a_d    = nx_a_q;
      mode_a_d  = mode_a_q;
      nv_a_d    = nv_a_q;
      of_a_d    = of_a_q;
      uf_a_d    = uf_a_q;
      if (!stall_s) begin
         valid_a_d = data_valid_i;
      end else begin
         valid_a_d = valid_a_q;
      end
      if (in_xfer_s) begin
         sign_a_d = result_i[31];
         mag_a_d  = result_i[30:0];
         inc_a_d  = round_up(mode_in_s, result_i[31], round_bits_i, result_i[0]);
         nx_a_d   = |round_bits_i;
         mode_a_d = mode_in_s;
         nv_a_d   = invalid_operation_i;
         of_a_d   = overflow_i;
         uf_a_d   = underflow_i;
      end else begin
         mode_a_d = mode_a_q;
      end
   end

   // Stage B: apply the increment and resolve exceptions in priority order
   always_comb begin
      sum_s = mag_a_q + {30'd0, inc_a_q};
      res_s = {sign_a_q, sum_s};
      flg_s = {3'b000, nx_a_q & (sum_s[30:23] == 8'h00), nx_a_q};
      if (nv_a_q) begin
         res_s = CANONICAL_NAN;
         flg_s = 5'b10000;
      end else if (of_a_q || (sum_s[30:23] == 8'hFF)) begin
         res_s = overflow_value(mode_a_q, sign_a_q);
         flg_s = 5'b00101;
      end else if (uf_a_q) begin
         res_s = {sign_a_q, 30'd0,
                  ((mode_a_q == RUP) & ~sign_a_q) | ((mode_a_q == RDN) & sign_a_q)};
         flg_s = 5'b00011;
      end else begin
         flg_s = {3'b000, nx_a_q & (sum_s[30:23] == 8'h00), nx_a_q};
      end

      valid_b_d = valid_b_q;
      result_d  = result_q;
      flags_d   = flags_q;
      if (!stall_s) begin
         valid_b_d = valid_a_q;
         if (valid_a_q) begin
            result_d = res_s;
            flags_d  = flg_s;
         end else begin
            flags_d  = flags_q;
         end
      end else begin
         valid_b_d = valid_b_q;
      end
      // Clear is applied first so a coincident transfer leaves only its own flags
      acc_d = (clear_flags_i ? 5'b00000 : acc_q) | (out_xfer_s ? flags_q : 5'b00000);
   end

   // Pipeline and flag registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         valid_a_q <= 1'b0;
         sign_a_q  <= 1'b0;
         mag_a_q   <= 31'd0;
         inc_a_q   <= 1'b0;
         nx_a_q    <= 1'b0;
         mode_a_q  <= 3'd0;
         nv_a_q    <= 1'b0;
         of_a_q    <= 1'b0;
         uf_a_q    <= 1'b0;
         valid_b_q <= 1'b0;
         result_q  <= 32'd0;
         flags_q   <= 5'd0;
         acc_q     <= 5'd0;
      end else begin
         valid_a_q <= valid_a_d;
         sign_a_q  <= sign_a_d;
         mag_a_q   <= mag_a_d;
         inc_a_q   <= inc_a_d;
         nx_a_q    <= nx_a_d;
         mode_a_q  <= mode_a_d;
         nv_a_q    <= nv_a_d;
         of_a_q    <= of_a_d;
         uf_a_q    <= uf_a_d;
         valid_b_q <= valid_b_d;
         result_q  <= result_d;
         flags_q   <= flags_d;
         acc_q     <= acc_d;
      end
   end
endmodule

// File: tb/tb_floating_point_rounder.sv
// Self-checking bench for floating_point_rounder: directed corner cases, backpressure,
// flag clear/reset, then randomized traffic against a behavioural rounding model.
module tb_floating_point_rounder;
   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic [31:0] result_i = 32'd0;
   logic [2:0]  round_bits_i = 3'd0;
   logic        invalid_operation_i = 1'b0;
   logic        overflow_i = 1'b0;
   logic        underflow_i = 1'b0;
   logic [2:0]  round_mode_i = 3'd0;
   logic        data_valid_i = 1'b0;
   logic        ready_o;
   logic        data_valid_o;
   logic        ready_i = 1'b1;
   logic [31:0] result_o;
   logic [4:0]  flags_o;
   logic        clear_flags_i = 1'b0;
   logic [4:0]  acc_flags_o;

   floating_point_rounder dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .result_i(result_i), .round_bits_i(round_bits_i),
      .invalid_operation_i(invalid_operation_i), .overflow_i(overflow_i),
      .underflow_i(underflow_i), .round_mode_i(round_mode_i), .data_valid_i(data_valid_i),
      .ready_o(ready_o), .data_valid_o(data_valid_o), .ready_i(ready_i),
      .result_o(result_o), .flags_o(flags_o), .clear_flags_i(clear_flags_i),
      .acc_flags_o(acc_flags_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct { logic [31:0] res; logic [4:0] fl; int rem; } item_t;
   item_t       q[$];
   logic [4:0]  acc_m = 5'd0;
   logic [31:0] nxt_res = 32'd0;
   logic [4:0]  nxt_fl = 5'd0;
   int          checks = 0;
   int          fails = 0;

   task automatic chk(input string tag, input logic [36:0] got, input logic [36:0] exp);
      checks++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Rounding reference: returns {result, flags}
   function automatic logic [36:0] ref_round(input logic [31:0] r, input logic [2:0] grs,
         input logic inv, input logic ovf, input logic unf, input logic [2:0] mode);
      int m;
      logic sgn, nx, up, to_inf, tiny;
      logic [31:0] mag;
      m   = (mode > 3'd4) ? 0 : int'(mode);
      sgn = r[31];
      nx  = |grs;
      case (m)
         0: up = grs[2] && (grs[1] || grs[0] || r[0]);
         1: up = 1'b0;
         2: up = sgn && nx;
         3: up = !sgn && nx;
         default: up = grs[2];
      endcase
      mag = {1'b0, r[30:0]} + 32'(up);
      mag[31] = 1'b0;
      if (inv) return {32'h7FC00000, 5'b10000};
      if (ovf || mag[30:23] == 8'hFF) begin
         to_inf = (m == 0) || (m == 4) || (m == 2 && sgn) || (m == 3 && !sgn);
         return {sgn, to_inf ? 31'h7F800000 : 31'h7F7FFFFF, 5'b00101};
      end
      if (unf) begin
         tiny = (m == 3 && !sgn) || (m == 2 && sgn);
         return {sgn, 30'd0, tiny, 5'b00011};
      end
      return {sgn, mag[30:0], 3'b000, nx && (mag[30:23] == 8'd0), nx};
   endfunction

   // One clock: check outputs against the model, then advance the model across the edge
   task automatic step(output bit took);
      bit exp_dv, out_x, stall;
      #1;
      exp_dv = (q.size() > 0) && (q[0].rem == 0);
      stall  = exp_dv && !ready_i;
      chk("data_valid_o", 37'(data_valid_o), 37'(exp_dv));
      chk("ready_o", 37'(ready_o), 37'(!stall));
      chk("acc_flags_o", 37'(acc_flags_o), 37'(acc_m));
      if (exp_dv) begin
         chk("result_o", 37'(result_o), 37'(q[0].res));
         chk("flags_o", 37'(flags_o), 37'(q[0].fl));
      end
      took  = data_valid_i && !stall;
      out_x = exp_dv && ready_i;
      acc_m = (clear_flags_i ? 5'd0 : acc_m) | (out_x ? q[0].fl : 5'd0);
      if (!stall) begin
         if (out_x) void'(q.pop_front());
         foreach (q[i]) if (q[i].rem > 0) q[i].rem = q[i].rem - 1;
         if (took) q.push_back('{res: nxt_res, fl: nxt_fl, rem: 1});
      end
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic drive(input logic [31:0] r, input logic [2:0] grs, input logic inv,
         input logic ovf, input logic unf, input logic [2:0] m,
         input logic [31:0] er, input logic [4:0] ef);
      result_i = r; round_bits_i = grs; invalid_operation_i = inv;
      overflow_i = ovf; underflow_i = unf; round_mode_i = m;
      data_valid_i = 1'b1; nxt_res = er; nxt_fl = ef;
   endtask

   task automatic drive_model(input logic [31:0] r, input logic [2:0] grs, input logic inv,
         input logic ovf, input logic unf, input logic [2:0] m);
      logic [36:0] e;
      e = ref_round(r, grs, inv, ovf, unf, m);
      drive(r, grs, inv, ovf, unf, m, e[36:5], e[4:0]);
   endtask

   task automatic drive_random();
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 3) == 0) r[30:23] = 8'hFE;
      if ($urandom_range(0, 7) == 0) r[30:23] = 8'h00;
      drive_model(r, 3'($urandom_range(0, 7)), $urandom_range(0, 15) == 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                  3'($urandom_range(0, 7)));
   endtask

   task automatic send(input logic [31:0] r, input logic [2:0] grs, input logic inv,
         input logic ovf, input logic unf, input logic [2:0] m,
         input logic [31:0] er, input logic [4:0] ef);
      bit took;
      int n;
      n = 0;
      drive(r, grs, inv, ovf, unf, m, er, ef);
      do begin
         step(took);
         n++;
      end while (!took && n < 20);
      if (!took) chk("send_timeout", 37'(took), 37'(1));
      data_valid_i = 1'b0;
   endtask

   task automatic drain();
      bit took;
      int n;
      n = 0;
      data_valid_i = 1'b0;
      ready_i = 1'b1;
      while (q.size() > 0 && n < 20) begin
         step(took);
         n++;
      end
      chk("drain_empty", 37'(q.size()), 37'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit took;
      int idx;
      // Reset state while rst_n_i is held low
      repeat (2) @(negedge clk_i);
      chk("rst_valid", 37'(data_valid_o), 37'(0));
      chk("rst_result", 37'(result_o), 37'(0));
      chk("rst_flags", 37'(flags_o), 37'(0));
      chk("rst_acc", 37'(acc_flags_o), 37'(0));
      rst_n_i = 1'b1;
      @(negedge clk_i);

      // Directed corner cases, issued back to back
      send(32'h3F800000, 3'b100, 0, 0, 0, 3'd0, 32'h3F800000, 5'b00001);
      send(32'h3F800001, 3'b100, 0, 0, 0, 3'd0, 32'h3F800002, 5'b00001);
      send(32'h3FFFFFFF, 3'b100, 0, 0, 0, 3'd0, 32'h40000000, 5'b00001);
      send(32'h3FFFFFFF, 3'b100, 0, 0, 0, 3'd1, 32'h3FFFFFFF, 5'b00001);
      send(32'h7F7FFFFF, 3'b100, 0, 0, 0, 3'd0, 32'h7F800000, 5'b00101);
      send(32'h7F7FFFFF, 3'b100, 0, 1, 0, 3'd1, 32'h7F7FFFFF, 5'b00101);
      send(32'hFF7FFFFF, 3'b100, 0, 0, 0, 3'd3, 32'hFF7FFFFF, 5'b00001);
      send(32'h12345678, 3'b011, 1, 1, 1, 3'd2, 32'h7FC00000, 5'b10000);
      send(32'h00000000, 3'b001, 0, 0, 1, 3'd3, 32'h00000001, 5'b00011);
      send(32'h80000000, 3'b001, 0, 0, 1, 3'd2, 32'h80000001, 5'b00011);
      send(32'h80000000, 3'b001, 0, 0, 1, 3'd3, 32'h80000000, 5'b00011);
      send(32'hFF000000, 3'b000, 0, 1, 0, 3'd2, 32'hFF800000, 5'b00101);
      send(32'h7F000000, 3'b000, 0, 1, 0, 3'd2, 32'h7F7FFFFF, 5'b00101);
      send(32'h40000000, 3'b100, 0, 0, 0, 3'd4, 32'h40000001, 5'b00001);
      send(32'h40000000, 3'b100, 0, 0, 0, 3'd6, 32'h40000000, 5'b00001);
      send(32'h007FFFFF, 3'b010, 0, 0, 0, 3'd3, 32'h00800000, 5'b00001);
      send(32'h00000004, 3'b010, 0, 0, 0, 3'd1, 32'h00000004, 5'b00011);
      drain();
      chk("acc_accumulated", 37'(acc_flags_o), 37'(5'b10111));

      // Backpressure: 3 back-to-back inputs, ready_i low for 4 cycles from first output
      idx = 0;
      for (int c = 0; c < 14; c++) begin
         ready_i = !(c >= 2 && c < 6);
         case (idx)
            0: drive_model(32'h3F800001, 3'b110, 0, 0, 0, 3'd0);
            1: drive_model(32'hC0000003, 3'b001, 0, 0, 0, 3'd2);
            2: drive_model(32'h7F7FFFFF, 3'b111, 0, 0, 0, 3'd3);
            default: data_valid_i = 1'b0;
         endcase
         step(took);
         if (took) idx++;
      end
      chk("bp_all_sent", 37'(idx), 37'(3));
      drain();

      // NX then OF accumulate; clear coincident with an NV transfer leaves only NV
      clear_flags_i = 1'b1;
      step(took);
      clear_flags_i = 1'b0;
      send(32'h3F800000, 3'b001, 0, 0, 0, 3'd0, 32'h3F800000, 5'b00001);
      send(32'h7F000000, 3'b000, 0, 1, 0, 3'd0, 32'h7F800000, 5'b00101);
      drain();
      chk("acc_nx_of", 37'(acc_flags_o), 37'(5'b00101));
      send(32'h00000000, 3'b000, 1, 0, 0, 3'd0, 32'h7FC00000, 5'b10000);
      step(took);
      clear_flags_i = 1'b1;
      step(took);
      clear_flags_i = 1'b0;
      chk("acc_clear_nv", 37'(acc_flags_o), 37'(5'b10000));
      drain();

      // Asynchronous reset mid-stream
      drive_random();
      step(took);
      drive_random();
      step(took);
      data_valid_i = 1'b0;
      #2 rst_n_i = 1'b0;
      #1;
      chk("mid_rst_valid", 37'(data_valid_o), 37'(0));
      chk("mid_rst_acc", 37'(acc_flags_o), 37'(0));
      chk("mid_rst_result", 37'(result_o), 37'(0));
      q.delete();
      acc_m = 5'd0;
      @(negedge clk_i);
      rst_n_i = 1'b1;
      @(negedge clk_i);
      drain();

      // Randomized traffic with random backpressure and clears
      for (int c = 0; c < 500; c++) begin
         ready_i = $urandom_range(0, 3) != 0;
         clear_flags_i = $urandom_range(0, 19) == 0;
         if ($urandom_range(0, 9) < 7) drive_random();
         else data_valid_i = 1'b0;
         step(took);
      end
      clear_flags_i = 1'b0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/floating_point_rounder.md
Name: floating_point_rounder

Overview:
Post-multiplication rounding stage for the FPU. It consumes the truncated result, guard/round/sticky bits and exception flags produced by the floating point multiplier, and applies the IEEE-754 rounding mode. It emits the final rounded float32 result with per-operation exception flags, and keeps an accumulated fflags register for the CSR unit.
Two-stage valid/ready pipeline with a global stall, placed between the multiplier output and the FPU writeback arbiter.

Parameters:
CANONICAL_NAN, 32'h7FC00000, value returned for invalid operations
ROUND_MODE_W, 3, width of the rounding mode field (RISC-V frm encoding)

Ports:
clk_i  input  1  clock
rst_n_i  input  1  asynchronous active-low reset
result_i  input  32 (float32_t)  unrounded result: sign, exponent, truncated mantissa
round_bits_i  input  3 (round_bits_t)  guard, round, sticky
invalid_operation_i  input  1  invalid flag from the multiplier
overflow_i  input  1  overflow flag from the multiplier
underflow_i  input  1  underflow flag from the multiplier
round_mode_i  input  3  0=RNE 1=RTZ 2=RDN 3=RUP 4=RMM; 5-7 treated as RNE
data_valid_i  input  1  input transfer valid
ready_o  output  1  rounder can accept an input
data_valid_o  output  1  output valid
ready_i  input  1  downstream accepts the output
result_o  output  32 (float32_t)  rounded result
flags_o  output  5  {NV,DZ,OF,UF,NX} for this operation; DZ is always 0
clear_flags_i  input  1  clears the accumulated flags
acc_flags_o  output  5  sticky OR of flags_o over all completed transfers

Behaviour:
- Reset: all valids 0, result_o 0, flags_o 0, acc_flags_o 0. Reset is asynchronous and may occur mid-operation; in-flight data is discarded.
- Stall condition: stall = data_valid_o & !ready_i. ready_o = !stall, combinational.
- When stalled, both stages hold their contents. A transfer happens only when data_valid_i & ready_o.
- Latency: 2 cycles from input transfer to data_valid_o when there is no stall. Throughput is 1 per cycle. Back-to-back transfers keep order.
- Stage A (registered), computes:
  - inexact = G|R|S
  - increment: RNE = G&(R|S|lsb); RTZ = 0; RDN = sign&inexact; RUP = !sign&inexact; RMM = G
  - Registers: sign, {exponent,mantissa}, increment, inexact, mode, input flags.
- Stage B (registered):
  - sum = {exponent,mantissa} + increment, 31-bit. A mantissa carry propagates into the exponent naturally.
  - If sum exponent == 8'hFF: overflow after rounding.
- Output priority (highest first):
  1. invalid: result = CANONICAL_NAN, flags = NV only.
  2. overflow_i or post-round overflow: flags OF|NX. The result depends on mode:
     - RNE, RMM → infinity.
     - RTZ → max finite 0x7F7FFFFF with sign.
     - RDN → +max finite for positive, -inf for negative.
     - RUP → +inf for positive, -max finite for negative.
  3. underflow_i: flags UF|NX. Result is signed zero, except:
     - RUP & positive → 0x00000001.
     - RDN & negative → 0x80000001.
  4. otherwise: result = {sign, sum}, flags NX = inexact. UF = inexact & (sum exponent == 0).
- acc_flags_o updates on each output transfer (data_valid_o & ready_i): acc |= flags_o.
- clear_flags_i is applied before the OR in the same cycle. A simultaneous clear and transfer leaves exactly that transfer's flags.
- Input flags are sampled only on a transfer. Inputs presented while ready_o=0 are ignored. The multiplier must not issue under stall; that is enforced by the FPU issue logic.
- Once data_valid_o is asserted, result_o and flags_o stay stable until ready_i is high.

Test Plan:
- RNE tie, even LSB: 0x3F800000, G=1 R=0 S=0 → 0x3F800000, flags NX; with LSB=1 (0x3F800001) → 0x3F800002, NX.
- Mantissa carry: 0x3FFFFFFF, G=1, RNE → 0x40000000, NX. Same input with RTZ → 0x3FFFFFFF, NX.
- Post-round overflow: 0x7F7FFFFF, G=1 → RNE 0x7F800000 with OF|NX; RTZ 0x7F7FFFFF with OF|NX; negative input with RUP → 0xFF7FFFFF.
- Special flags:
  - invalid_operation_i=1 with any result → 0x7FC00000, flags 5'b10000.
  - underflow_i=1, positive, RUP → 0x00000001, UF|NX.
- Backpressure: issue 3 back-to-back transfers with ready_i low for 4 cycles from the first output.
  - Required: ready_o low during the stall, outputs held stable, all 3 results delivered in order, none lost or duplicated.
- Flags and reset: accumulate NX then OF; assert clear_flags_i in the same cycle as an NV transfer → acc_flags_o = 5'b10000. Assert rst_n_i low mid-stream → all valids and acc_flags_o are 0 immediately.
